// File: rtl/if_id_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// if_id_fetch_ctrl
//   This is the fetch-side controller for the 5-stage WISC-SP20 pipeline.
//   It owns the PC register and the IF/ID pipeline register, and it acts on
//   the stall_decode and flush_fetch controls from the hazard unit:
//     - A stall holds the PC and IF/ID.
//     - A flush redirects the PC and injects NOP bubbles into IF/ID.
//     - A HALT instruction freezes fetch until a flush or a reset.
//   It also keeps a saturating count of stalled cycles for performance debug.
//
// Parameters
//   RESET_PC      PC value loaded on reset.
//   FLUSH_CYCLES  Bubbles injected per flush (>=1). 1 means the redirect cycle only.
//   NOP_INSTR     Encoding placed in IF/ID when a bubble is injected.
//
// Ports
//   clk           in   1   clock; all state changes on the rising edge
//   rst           in   1   synchronous, active-high reset
//   instr_in      in   16  instruction read from imem at pc_out (same cycle)
//   stall_decode  in   1   hold PC and IF/ID this cycle
//   flush_fetch   in   1   squash IF/ID and load the PC from pc_redirect
//   pc_redirect   in   16  branch/jump target, used only while flush_fetch=1
//   pc_out        out  16  current fetch address to imem
//   instr_IF_ID   out  16  registered instruction to decode
//   pc2_IF_ID     out  16  registered PC+2 of that instruction
//   valid_IF_ID   out  1   IF/ID holds a real (non-bubble) instruction
//   halted        out  1   fetch is frozen after a HALT was latched
//   stall_count   out  16  saturating count of stalled cycles
//
// All outputs come straight from registers. No input reaches an output
// through combinational logic.
// ---------------------------------------------------------------------------
module if_id_fetch_ctrl #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter logic [15:0] NOP_INSTR    = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr_in,
    input  logic        stall_decode,
    input  logic        flush_fetch,
    input  logic [15:0] pc_redirect,
    output logic [15:0] pc_out,
    output logic [15:0] instr_IF_ID,
    output logic [15:0] pc2_IF_ID,
    output logic        valid_IF_ID,
    output logic        halted,
    output logic [15:0] stall_count
);

    // flush_cnt only has to hold FLUSH_CYCLES-1. Keep at least one bit so the
    // single-bubble build still has a legal vector.
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [15:0]      r_pc;
    logic [15:0]      r_instr;
    logic [15:0]      r_pc2;
    logic             r_valid;
    logic             r_halted;
    logic [15:0]      r_stall_count;

    state_t           w_state_next;
    logic [CNT_W-1:0] w_flush_cnt_next;
    logic [15:0]      w_pc_next;
    logic [15:0]      w_instr_next;
    logic [15:0]      w_pc2_next;
    logic             w_valid_next;
    logic             w_halted_next;
    logic [15:0]      w_stall_count_next;

    logic [15:0]      w_pc_plus2;
    logic             w_is_halt;

    // This add wraps naturally: 16'hFFFE + 2 gives 16'h0000.
    assign w_pc_plus2 = r_pc + 16'd2;
    // A HALT is any instruction whose opcode field [15:11] is all zeros.
    assign w_is_halt  = (instr_in[15:11] == 5'b00000);

    // -----------------------------------------------------------------------
    // Next-state logic.
    // The priority is flush > stall > normal per-state behaviour.
    // Reset is handled in the register process.
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next       = r_state;
        w_flush_cnt_next   = r_flush_cnt;
        w_pc_next          = r_pc;
        w_instr_next       = r_instr;
        w_pc2_next         = r_pc2;
        w_valid_next       = r_valid;
        w_halted_next      = r_halted;
        w_stall_count_next = r_stall_count;

        if (flush_fetch) begin
            // The redirect cycle is itself the first bubble.
            w_pc_next     = pc_redirect;
            w_instr_next  = NOP_INSTR;
            w_valid_next  = 1'b0;
            w_halted_next = 1'b0;
            if (FLUSH_CYCLES > 1) begin
                w_state_next     = ST_FLUSH;
                w_flush_cnt_next = CNT_RELOAD;
            end else begin
                w_state_next     = ST_RUN;
                w_flush_cnt_next = '0;
            end
        end else if (stall_decode && (r_state != ST_HALTED)) begin
            // Everything holds, including any bubble countdown in progress.
            if (r_stall_count != 16'hFFFF) begin
                w_stall_count_next = r_stall_count + 16'd1;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    w_instr_next = instr_in;
                    w_pc2_next   = w_pc_plus2;
                    w_valid_next = 1'b1;
                    if (w_is_halt) begin
                        // The HALT itself moves on to decode.
                        // The PC parks on its address.
                        w_halted_next = 1'b1;
                        w_state_next  = ST_HALTED;
                    end else begin
                        w_pc_next = w_pc_plus2;
                    end
                end
                ST_FLUSH: begin
                    w_instr_next = NOP_INSTR;
                    w_valid_next = 1'b0;
                    if (r_flush_cnt <= CNT_W'(1)) begin
                        w_state_next     = ST_RUN;
                        w_flush_cnt_next = '0;
                    end else begin
                        w_flush_cnt_next = r_flush_cnt - CNT_W'(1);
                    end
                end
                ST_HALTED: begin
                    // Frozen. Only a flush or a reset can leave this state.
                end
                default: begin
                    w_state_next = ST_RUN;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_flush_cnt   <= '0;
            r_pc          <= RESET_PC;
            r_instr       <= NOP_INSTR;
            r_pc2         <= 16'h0000;
            r_valid       <= 1'b0;
            r_halted      <= 1'b0;
            r_stall_count <= 16'h0000;
        end else begin
            r_state       <= w_state_next;
            r_flush_cnt   <= w_flush_cnt_next;
            r_pc          <= w_pc_next;
            r_instr       <= w_instr_next;
            r_pc2         <= w_pc2_next;
            r_valid       <= w_valid_next;
            r_halted      <= w_halted_next;
            r_stall_count <= w_stall_count_next;
        end
    end

    assign pc_out      = r_pc;
    assign instr_IF_ID = r_instr;
    assign pc2_IF_ID   = r_pc2;
    assign valid_IF_ID = r_valid;
    assign halted      = r_halted;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_if_id_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_if_id_fetch_ctrl
//   This bench builds two copies of if_id_fetch_ctrl: one with a single-cycle
//   flush and one with a three-bubble flush. Both copies see the same inputs.
//   The directed scenarios check against fixed expected values.
//   The randomized run checks against a behavioural model. The model tracks
//   a count of bubbles still owed and a halted flag.
// ---------------------------------------------------------------------------
module tb_if_id_fetch_ctrl;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst, stall_decode, flush_fetch;
    logic [15:0] instr_in, pc_redirect;

    logic [15:0] pc_1, instr_1, pc2_1, stall_1;
    logic        valid_1, halted_1;
    logic [15:0] pc_3, instr_3, pc2_3, stall_3;
    logic        valid_3, halted_3;

    always #5 clk = ~clk;

    if_id_fetch_ctrl #(.RESET_PC(16'h0000), .FLUSH_CYCLES(1), .NOP_INSTR(NOP)) dut1 (
        .clk(clk), .rst(rst), .instr_in(instr_in), .stall_decode(stall_decode),
        .flush_fetch(flush_fetch), .pc_redirect(pc_redirect), .pc_out(pc_1),
        .instr_IF_ID(instr_1), .pc2_IF_ID(pc2_1), .valid_IF_ID(valid_1),
        .halted(halted_1), .stall_count(stall_1)
    );

    if_id_fetch_ctrl #(.RESET_PC(16'h0000), .FLUSH_CYCLES(3), .NOP_INSTR(NOP)) dut3 (
        .clk(clk), .rst(rst), .instr_in(instr_in), .stall_decode(stall_decode),
        .flush_fetch(flush_fetch), .pc_redirect(pc_redirect), .pc_out(pc_3),
        .instr_IF_ID(instr_3), .pc2_IF_ID(pc2_3), .valid_IF_ID(valid_3),
        .halted(halted_3), .stall_count(stall_3)
    );

    // Packed snapshot {pc, instr, pc2, valid, halted, stall_count} per instance
    logic [65:0] obs [2];
    assign obs[0] = {pc_1, instr_1, pc2_1, valid_1, halted_1, stall_1};
    assign obs[1] = {pc_3, instr_3, pc2_3, valid_3, halted_3, stall_3};

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state, one entry per instance
    int          fc [2] = '{1, 3};
    logic [15:0] m_pc [2], m_instr [2], m_pc2 [2], m_stall [2];
    logic        m_valid [2], m_halted [2];
    int          m_left [2];

    task automatic model_tick();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pc[k] = 16'h0000; m_instr[k] = NOP; m_pc2[k] = 16'h0000;
                m_valid[k] = 1'b0; m_halted[k] = 1'b0; m_stall[k] = 16'h0000;
                m_left[k] = 0;
            end else if (flush_fetch) begin
                m_pc[k] = pc_redirect; m_instr[k] = NOP; m_valid[k] = 1'b0;
                m_halted[k] = 1'b0; m_left[k] = fc[k] - 1;
            end else if (m_halted[k]) begin
                // frozen
            end else if (stall_decode) begin
                if (m_stall[k] != 16'hFFFF) m_stall[k] = m_stall[k] + 16'd1;
            end else if (m_left[k] > 0) begin
                m_instr[k] = NOP; m_valid[k] = 1'b0; m_left[k] = m_left[k] - 1;
            end else begin
                m_instr[k] = instr_in;
                m_pc2[k]   = m_pc[k] + 16'd2;
                m_valid[k] = 1'b1;
                if (instr_in[15:11] == 5'd0) m_halted[k] = 1'b1;
                else                         m_pc[k] = m_pc[k] + 16'd2;
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, advance the model, then settle
    // for sampling.
    task automatic step(input logic r, input logic f, input logic s,
                        input logic [15:0] redir, input logic [15:0] ins);
        rst = r; flush_fetch = f; stall_decode = s; pc_redirect = redir; instr_in = ins;
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic test_reset();
        logic [65:0] exp_v;
        step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h4000);
        exp_v = {16'h0000, NOP, 16'h0000, 1'b0, 1'b0, 16'h0000};
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs[k] !== exp_v) $display("FAIL reset_state[%0d]: got %h want %h", k, obs[k], exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_free_run();
        for (int c = 1; c <= 4; c++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h4000);
            n_checks++;
            if (pc_1 !== 16'(2*c)) $display("FAIL free_pc c%0d: got %h want %h", c, pc_1, 16'(2*c));
            else n_pass++;
            n_checks++;
            if ({pc2_1, valid_1, instr_1} !== {16'(2*c), 1'b1, 16'h4000})
                $display("FAIL free_ifid c%0d: got %h/%b/%h want %h/1/4000", c, pc2_1, valid_1, instr_1, 16'(2*c));
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        repeat (4) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h4000);   // pc now 0x0010
        repeat (3) step(1'b0, 1'b0, 1'b1, 16'h0000, 16'h1234);
        n_checks++;
        if ({pc_1, instr_1, pc2_1, valid_1} !== {16'h0010, 16'h4000, 16'h0010, 1'b1})
            $display("FAIL stall_hold: got %h/%h/%h/%b want 0010/4000/0010/1", pc_1, instr_1, pc2_1, valid_1);
        else n_pass++;
        n_checks++;
        if (stall_1 !== 16'd3) $display("FAIL stall_count: got %0d want 3", stall_1);
        else n_pass++;
        step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h5555);
        n_checks++;
        if ({pc_1, instr_1, pc2_1} !== {16'h0012, 16'h5555, 16'h0012})
            $display("FAIL stall_resume: got %h/%h/%h want 0012/5555/0012", pc_1, instr_1, pc2_1);
        else n_pass++;
    endtask

    task automatic test_flush_with_stall();
        step(1'b0, 1'b1, 1'b1, 16'h0100, 16'h4000);
        n_checks++;
        if ({pc_1, instr_1, valid_1} !== {16'h0100, NOP, 1'b0})
            $display("FAIL flush_stall_regs: got %h/%h/%b want 0100/0800/0", pc_1, instr_1, valid_1);
        else n_pass++;
        n_checks++;
        if (stall_1 !== 16'd3) $display("FAIL flush_stall_count: got %0d want 3", stall_1);
        else n_pass++;
        step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h6000);
        n_checks++;
        if ({pc_1, instr_1, pc2_1, valid_1} !== {16'h0102, 16'h6000, 16'h0102, 1'b1})
            $display("FAIL flush1_refetch: got %h/%h/%h/%b want 0102/6000/0102/1", pc_1, instr_1, pc2_1, valid_1);
        else n_pass++;
    endtask

    task automatic test_multi_flush();
        step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h4000);
        step(1'b0, 1'b1, 1'b0, 16'h0040, 16'h4000);
        for (int b = 1; b <= 3; b++) begin
            n_checks++;
            if ({pc_3, instr_3, valid_3} !== {16'h0040, NOP, 1'b0})
                $display("FAIL flush3_bubble%0d: got %h/%h/%b want 0040/0800/0", b, pc_3, instr_3, valid_3);
            else n_pass++;
            step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h4000);
        end
        n_checks++;
        if ({pc_3, instr_3, pc2_3, valid_3} !== {16'h0042, 16'h4000, 16'h0042, 1'b1})
            $display("FAIL flush3_refetch: got %h/%h/%h/%b want 0042/4000/0042/1", pc_3, instr_3, pc2_3, valid_3);
        else n_pass++;
    endtask

    task automatic test_halt();
        step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h4000);
        repeat (16) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h4000);  // pc now 0x0020
        step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        n_checks++;
        if ({halted_1, pc_1, instr_1, pc2_1, valid_1} !== {1'b1, 16'h0020, 16'h0000, 16'h0022, 1'b1})
            $display("FAIL halt_latch: got %b/%h/%h/%h/%b want 1/0020/0000/0022/1",
                     halted_1, pc_1, instr_1, pc2_1, valid_1);
        else n_pass++;
        repeat (3) step(1'b0, 1'b0, 1'b1, 16'h0000, 16'h7777);
        n_checks++;
        if ({halted_1, pc_1, instr_1, stall_1} !== {1'b1, 16'h0020, 16'h0000, 16'h0000})
            $display("FAIL halt_frozen: got %b/%h/%h/%0d want 1/0020/0000/0", halted_1, pc_1, instr_1, stall_1);
        else n_pass++;
        step(1'b0, 1'b1, 1'b0, 16'h0080, 16'h4000);
        n_checks++;
        if ({halted_1, pc_1, valid_1} !== {1'b0, 16'h0080, 1'b0})
            $display("FAIL halt_exit: got %b/%h/%b want 0/0080/0", halted_1, pc_1, valid_1);
        else n_pass++;
    endtask

    task automatic test_wrap_sat_reset();
        step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h4000);
        step(1'b0, 1'b1, 1'b0, 16'hFFFE, 16'h4000);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h4000);
        n_checks++;
        if ({pc_1, pc2_1} !== {16'h0000, 16'h0000})
            $display("FAIL pc_wrap: got %h/%h want 0000/0000", pc_1, pc2_1);
        else n_pass++;
        repeat (65535) step(1'b0, 1'b0, 1'b1, 16'h0000, 16'h4000);
        n_checks++;
        if (stall_1 !== 16'hFFFF) $display("FAIL stall_reach_max: got %h want ffff", stall_1);
        else n_pass++;
        step(1'b0, 1'b0, 1'b1, 16'h0000, 16'h4000);
        n_checks++;
        if (stall_1 !== 16'hFFFF) $display("FAIL stall_saturate: got %h want ffff", stall_1);
        else n_pass++;
        step(1'b0, 1'b1, 1'b0, 16'h0200, 16'h4000);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h4000);
        n_checks++;
        if ({pc_3, valid_3} !== {16'h0200, 1'b0})
            $display("FAIL mid_flush_setup: got %h/%b want 0200/0", pc_3, valid_3);
        else n_pass++;
        step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h4000);
        n_checks++;
        if (obs[1] !== {16'h0000, NOP, 16'h0000, 1'b0, 1'b0, 16'h0000})
            $display("FAIL rst_mid_flush: got %h want %h", obs[1], {16'h0000, NOP, 16'h0000, 1'b0, 1'b0, 16'h0000});
        else n_pass++;
        // The reset must also cancel the remaining bubbles.
        step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h4000);
        n_checks++;
        if ({pc_3, valid_3} !== {16'h0002, 1'b1})
            $display("FAIL rst_cancels_flush: got %h/%b want 0002/1", pc_3, valid_3);
        else n_pass++;
    endtask

    task automatic test_random();
        logic        r, f, s;
        logic [15:0] redir, ins;
        logic [65:0] exp_v;
        step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h4000);
        for (int c = 0; c < 800; c++) begin
            r     = ($urandom_range(0, 99) == 0);
            f     = ($urandom_range(0, 7) == 0);
            s     = ($urandom_range(0, 3) == 0);
            redir = 16'($urandom) & 16'hFFFE;
            ins   = 16'($urandom);
            if ($urandom_range(0, 15) == 0) ins[15:11] = 5'd0;
            step(r, f, s, redir, ins);
            for (int k = 0; k < 2; k++) begin
                exp_v = {m_pc[k], m_instr[k], m_pc2[k], m_valid[k], m_halted[k], m_stall[k]};
                n_checks++;
                if (obs[k] !== exp_v)
                    $display("FAIL random[%0d] c%0d: got %h want %h", k, c, obs[k], exp_v);
                else n_pass++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush_fetch = 1'b0; stall_decode = 1'b0;
        pc_redirect = 16'h0000; instr_in = 16'h4000;
        test_reset();
        test_free_run();
        test_stall();
        test_flush_with_stall();
        test_multi_flush();
        test_halt();
        test_wrap_sat_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
